// File: rtl/instr_feeder.sv
// Instruction feeder for the DIN/Run/Done processor core.
// Holds a writable program memory and issues one instruction (plus its immediate for mvi) per core instruction.
module instr_feeder #(
  parameter int AW = 5,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ProgWe,
  input  logic [AW-1:0] ProgAddr,
  input  logic [DW-1:0] ProgData,
  input  logic          Start,
  input  logic [AW-1:0] LastAddr,
  input  logic          Done,
  output logic [DW-1:0] DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Finished,
  output logic          ErrTimeout,
  output logic [CW-1:0] InstrCount
);

  localparam logic [2:0] OpMvi = 3'b001;

  typedef enum logic [1:0] {IDLE, ISSUE, IMM, WAIT} stateT;

  stateT         state, stateNext;
  logic [DW-1:0] progMem [2**AW];
  logic [DW-1:0] memRd;
  logic [DW-1:0] heldWord;
  logic [AW-1:0] lastAddrReg;
  logic [1:0]    waitCnt;
  logic          last;
  logic          lastEff;
  logic          complete;
  logic          timeoutHit;
  logic          errReg;

  assign memRd = progMem[PC];

  // Program memory is not reset; the loader owns its contents.
  always_ff @(posedge Clock) begin
    if (ProgWe && !Busy) begin
      progMem[ProgAddr] <= ProgData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The immediate word of an mvi can itself sit at LastAddr, so IMM folds its own address into the last check.
  always_comb begin
    stateNext  = state;
    complete   = 1'b0;
    timeoutHit = 1'b0;
    lastEff    = last | ((state == IMM) && (PC == lastAddrReg));
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        stateNext = (memRd[15:13] == OpMvi) ? IMM : WAIT;
      end
      IMM: begin
        if (Done) begin
          complete = 1'b1;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (Done) begin
          complete = 1'b1;
        end else if (waitCnt == 2'd3) begin
          timeoutHit = 1'b1;
          complete   = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (complete) begin
      stateNext = lastEff ? IDLE : ISSUE;
    end
  end

  always_comb begin
    DIN = '0;
    case (state)
      ISSUE, IMM: DIN = memRd;
      WAIT:       DIN = heldWord;
      default:    DIN = '0;
    endcase
  end

  assign Run        = (state == ISSUE);
  assign Busy       = (state != IDLE);
  assign ErrTimeout = errReg | timeoutHit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      PC          <= '0;
      heldWord    <= '0;
      lastAddrReg <= '0;
      waitCnt     <= '0;
      last        <= 1'b0;
      errReg      <= 1'b0;
      Finished    <= 1'b0;
      InstrCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            lastAddrReg <= LastAddr;
            PC          <= '0;
            InstrCount  <= '0;
            errReg      <= 1'b0;
          end
        end
        ISSUE: begin
          PC       <= PC + AW'(1);
          last     <= (PC == lastAddrReg);
          waitCnt  <= 2'd1;
          heldWord <= memRd;
        end
        IMM: begin
          PC       <= PC + AW'(1);
          last     <= lastEff;
          heldWord <= memRd;
          if (!Done) begin
            waitCnt <= 2'd2;
          end
        end
        WAIT: begin
          if (!Done && (waitCnt != 2'd3)) begin
            waitCnt <= waitCnt + 2'd1;
          end
        end
        default: ;
      endcase
      if (timeoutHit) begin
        errReg <= 1'b1;
      end
      if (complete) begin
        InstrCount <= InstrCount + CW'(1);
      end
      Finished <= complete && lastEff;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder; the core side is modelled by driving Done by hand.
module tb_instr_feeder;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          Clock;
  logic          Reset;
  logic          ProgWe;
  logic [AW-1:0] ProgAddr;
  logic [DW-1:0] ProgData;
  logic          Start;
  logic [AW-1:0] LastAddr;
  logic          Done;
  logic [DW-1:0] DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Finished;
  logic          ErrTimeout;
  logic [CW-1:0] InstrCount;

  int assertCount = 0;
  int failCount   = 0;

  instr_feeder #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ProgWe     (ProgWe),
    .ProgAddr   (ProgAddr),
    .ProgData   (ProgData),
    .Start      (Start),
    .LastAddr   (LastAddr),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .PC         (PC),
    .Busy       (Busy),
    .Finished   (Finished),
    .ErrTimeout (ErrTimeout),
    .InstrCount (InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one clock and settle 2 time units past the rising edge.
  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ProgWe   = 1'b1;
    ProgAddr = addr;
    ProgData = data;
    step();
    ProgWe = 1'b0;
  endtask

  task automatic startRun(input logic [AW-1:0] lastA);
    LastAddr = lastA;
    Start    = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
    Start = 1'b0; LastAddr = '0; Done = 1'b0;
    #3;
    checkOutput("rst_run", Run, 0);
    checkOutput("rst_din", DIN, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_pc", PC, 0);
    checkOutput("rst_cnt", InstrCount, 0);
    checkOutput("rst_err", ErrTimeout, 0);
    checkOutput("rst_fin", Finished, 0);
    #9 Reset = 1'b0;
    step();

    $display("[TB] single mv, LastAddr=0");
    applyStimulus(5'd0, 16'h0400);
    startRun(5'd0);
    checkOutput("t1_run", Run, 1);
    checkOutput("t1_din", DIN, 16'h0400);
    checkOutput("t1_busy", Busy, 1);
    step();
    checkOutput("t1_wait_run", Run, 0);
    checkOutput("t1_wait_din", DIN, 16'h0400);
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t1_fin", Finished, 1);
    checkOutput("t1_busy_end", Busy, 0);
    checkOutput("t1_cnt", InstrCount, 1);
    checkOutput("t1_pc", PC, 1);
    step();
    checkOutput("t1_fin_pulse", Finished, 0);

    $display("[TB] mvi with immediate");
    applyStimulus(5'd0, 16'h2800);
    applyStimulus(5'd1, 16'h00A5);
    startRun(5'd1);
    checkOutput("t2_run", Run, 1);
    checkOutput("t2_din", DIN, 16'h2800);
    step();
    checkOutput("t2_imm_run", Run, 0);
    checkOutput("t2_imm_din", DIN, 16'h00A5);
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t2_fin", Finished, 1);
    checkOutput("t2_pc", PC, 2);
    checkOutput("t2_cnt", InstrCount, 1);

    $display("[TB] add then mv, Start while busy");
    applyStimulus(5'd0, 16'h4080);
    applyStimulus(5'd1, 16'h0400);
    startRun(5'd1);
    checkOutput("t3_run0", Run, 1);
    checkOutput("t3_din0", DIN, 16'h4080);
    step();
    checkOutput("t3_run1", Run, 0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    checkOutput("t3_run2", Run, 0);
    checkOutput("t3_pc_busy_start", PC, 1);
    step();
    checkOutput("t3_run3", Run, 0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t3_run4", Run, 1);
    checkOutput("t3_din4", DIN, 16'h0400);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t3_fin", Finished, 1);
    checkOutput("t3_cnt", InstrCount, 2);
    checkOutput("t3_err", ErrTimeout, 0);

    $display("[TB] opcode 111 without Done");
    applyStimulus(5'd0, 16'hE000);
    startRun(5'd1);
    checkOutput("t4_run0", Run, 1);
    step();
    step();
    checkOutput("t4_err_t2", ErrTimeout, 0);
    step();
    checkOutput("t4_err_t3", ErrTimeout, 1);
    step();
    checkOutput("t4_run4", Run, 1);
    checkOutput("t4_din4", DIN, 16'h0400);
    checkOutput("t4_cnt", InstrCount, 1);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t4_fin", Finished, 1);
    checkOutput("t4_cnt_end", InstrCount, 2);
    checkOutput("t4_err_sticky", ErrTimeout, 1);

    $display("[TB] ProgWe while busy is ignored");
    applyStimulus(5'd0, 16'h0400);
    startRun(5'd0);
    checkOutput("t5_err_cleared", ErrTimeout, 0);
    ProgWe = 1'b1; ProgAddr = 5'd0; ProgData = 16'hFFFF;
    step();
    ProgWe = 1'b0;
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t5_fin", Finished, 1);
    startRun(5'd0);
    checkOutput("t5_rerun_din", DIN, 16'h0400);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;

    $display("[TB] reset during add wait");
    applyStimulus(5'd0, 16'h4080);
    startRun(5'd0);
    step();
    checkOutput("t6_wait_busy", Busy, 1);
    checkOutput("t6_wait_din", DIN, 16'h4080);
    #1 Reset = 1'b1;
    #1;
    checkOutput("t6_rst_run", Run, 0);
    checkOutput("t6_rst_din", DIN, 0);
    checkOutput("t6_rst_busy", Busy, 0);
    checkOutput("t6_rst_pc", PC, 0);
    step();
    Reset = 1'b0;
    step();
    startRun(5'd0);
    checkOutput("t6_restart_run", Run, 1);
    checkOutput("t6_restart_pc", PC, 0);
    checkOutput("t6_restart_din", DIN, 16'h4080);
    step();
    step();
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    checkOutput("t6_fin", Finished, 1);
    checkOutput("t6_cnt", InstrCount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Drives the processor core's instruction side as the other end of its DIN/Run/Done handshake.
- Holds a small writable program memory and issues one instruction word per processor instruction; for mvi it also supplies the following word as the immediate.
- Waits for the core's Done (or the core's fixed 3-step limit), then issues the next word until a programmed last address is reached.
- Sits between the test/boot loader and the core; DIN and Run connect directly to the core.

Parameters:
- AW, 5, program memory address width (depth 2**AW words).
- DW, 16, instruction/data word width; must be 16 to match the core's DIN.
- CW, 8, width of the retired-instruction counter.

Ports:
- Clock  in  1  rising-edge clock, shared with the core.
- Reset  in  1  asynchronous, active-high reset.
- ProgWe  in  1  program memory write strobe; honoured only when Busy=0.
- ProgAddr  in  AW  program memory write address.
- ProgData  in  DW  program memory write data.
- Start  in  1  begin execution at address 0; sampled only in IDLE.
- LastAddr  in  AW  address of the final program word; latched on Start.
- Done  in  1  core completion strobe, combinational from the core.
- DIN  out  DW  word presented to the core.
- Run  out  1  one-cycle issue strobe to the core.
- PC  out  AW  address of the next word to be read.
- Busy  out  1  high in every state except IDLE.
- Finished  out  1  one-cycle pulse when the last instruction completes.
- ErrTimeout  out  1  sticky; set when an issued instruction reaches step T3 without Done.
- InstrCount  out  CW  number of instructions retired since Start; wraps.

Behaviour:
- Memory: 2**AW x DW register array.
  - Synchronous write on ProgWe and !Busy.
  - Combinational read at PC. Contents are not reset.
- Opcode field is DIN[15:13]; mvi = 3'b001. The core latches IR from DIN[15:7].
- Reset (async):
  - State=IDLE; PC=0; DIN=0; Run=0; Busy=0; Finished=0; ErrTimeout=0; InstrCount=0; WaitCnt=0; Last=0.
  - Run drops immediately on assertion, including mid-instruction.
- IDLE:
  - DIN=0, Run=0.
  - On Start: LastAddr is latched, PC=0, InstrCount=0, ErrTimeout=0, next state ISSUE.
- ISSUE (exactly 1 cycle; core is in T0):
  - Outputs: DIN=mem[PC], Run=1.
  - Updates: PC<=PC+1 (mod 2**AW); Last<=(PC==LastAddr); WaitCnt<=1.
  - Next state: IMM if opcode==mvi, else WAIT.
  - Done is ignored in this cycle.
- IMM (1 cycle; core is in T1 and routes DIN to the bus):
  - Outputs: DIN=mem[PC], Run=0.
  - Updates: PC<=PC+1; Last<=Last | (PC==LastAddr).
  - If Done=1, complete; otherwise go to WAIT with WaitCnt<=2.
- WAIT:
  - Outputs: Run=0; DIN holds the last issued word.
  - If Done=1, complete.
  - Else if WaitCnt==3 (core in T3), set ErrTimeout and complete.
  - Else WaitCnt<=WaitCnt+1.
- Complete (transition action):
  - InstrCount<=InstrCount+1.
  - If Last: next state IDLE, Finished=1 for one cycle, PC retained.
  - Otherwise: next state ISSUE in the following cycle. This aligns with the core's return to T0.
- Handshake latency:
  - mv/mvi issue-to-issue: 2 cycles.
  - add/sub issue-to-issue: 4 cycles.
  - Ops without Done: 4 cycles, with ErrTimeout set.
- Boundaries:
  - mvi at LastAddr still fetches its immediate from LastAddr+1, with wrap to 0 when LastAddr=2**AW-1.
  - PC wraps modulo 2**AW.
  - Start while Busy is ignored; ProgWe while Busy is ignored.
  - Done and Start in the same IDLE cycle: Start wins and Done is ignored.
  - LastAddr=0 runs exactly one instruction.

Test Plan:
- Load mem[0]=16'h0400 (mv R1,R0), LastAddr=0, Start -> Run=1 for 1 cycle with DIN=16'h0400; Done seen next cycle; Finished pulses 2 cycles after issue; InstrCount=1; PC=1.
- Load mvi R2 (16'h2800) at 0, mem[1]=16'h00A5, LastAddr=1, Start -> DIN=16'h2800 with Run, then DIN=16'h00A5 in the T1 cycle; Finished after 2 cycles; PC=2; InstrCount=1.
- add R0,R1 (16'h4080) then mv, LastAddr=1 -> second Run exactly 4 cycles after the first; InstrCount=2; ErrTimeout=0.
- Opcode 3'b111 word with Done held low -> ErrTimeout=1 in the T3 cycle; next issue 4 cycles after the first; execution continues.
- Assert Reset during WAIT of an add -> Run=0, DIN=0, Busy=0 immediately; a new Start restarts at PC=0.
- ProgWe while Busy writes mem[0] with 16'hFFFF -> memory unchanged; after Finished, re-run shows the original word on DIN.
